// File: rtl/queue_mp_pkg.sv
// rv32i_types: shared fetch-queue entry type and queue sizing constants
package rv32i_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_queue_t;
  localparam int FQ_ADDR_WIDTH = 4;
  localparam int FQ_PUSH_W = 2;
  localparam int FQ_POP_W = 2;
  localparam int FQ_AFULL = 12;
endpackage

// File: rtl/queue_mp_if.sv
// queue_mp_if: push/pop/flush bundle between fetch, the queue and decode
interface queue_mp_if import rv32i_types::*; #(
  parameter int DATA_W = $bits(fetch_queue_t),
  parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int PUSH_W = FQ_PUSH_W,
  parameter int POP_W = FQ_POP_W
);
  logic flush;
  logic [PUSH_W-1:0] push_valid;
  logic [PUSH_W*DATA_W-1:0] push_data;
  logic push_ready;
  logic [POP_W-1:0] out_valid;
  logic [POP_W*DATA_W-1:0] out_data;
  logic [$clog2(POP_W+1)-1:0] pop_cnt;
  logic [ADDR_WIDTH:0] count;
  logic almost_full;
  modport master (
    output flush, push_valid, push_data, pop_cnt,
    input push_ready, out_valid, out_data, count, almost_full
  );
  modport slave (
    input flush, push_valid, push_data, pop_cnt,
    output push_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/queue_mp_ptr_ctrl.sv
// queue_ptr_ctrl: pointers, occupancy, push/pop accounting and flush priority
module queue_ptr_ctrl #(
  parameter int AW = 4,
  parameter int PUSH_W = 2,
  parameter int POP_W = 2,
  parameter int AFULL = 12,
  parameter int PCW = $clog2(POP_W + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic [PUSH_W-1:0] push_valid,
  input  logic [PCW-1:0] pop_cnt,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0] count,
  output logic push_en,
  output logic push_ready,
  output logic almost_full
);
  localparam int DEPTH = 1 << AW;
  logic [AW:0] npush, npop;
  assign push_ready = ((AW+1)'(DEPTH) - count) >= (AW+1)'(PUSH_W);
  assign almost_full = count >= (AW+1)'(AFULL);
  assign push_en = push_ready && !flush;
  // accepted push lanes are counted only when the queue can take a full group; pops clamp to occupancy
  always_comb begin
    npush = '0;
    for (int i = 0; i < PUSH_W; i++) npush = npush + (AW+1)'(push_valid[i]);
    npush = push_en ? npush : '0;
    npop = ((AW+1)'(pop_cnt) > count) ? count : (AW+1)'(pop_cnt);
  end
  // reset and flush both empty the queue; otherwise advance pointers and occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(npush);
      rd_ptr <= rd_ptr + AW'(npop);
      count <= count + npush - npop;
    end
  // simulation-only warnings for dropped pushes, gapped lanes and over-pops
  always @(posedge clk)
    if (rst && !flush) begin
      assert (!(|push_valid) || push_ready) else $warning("push dropped while push_ready low");
      assert ((push_valid & (push_valid + PUSH_W'(1))) == '0) else $warning("non-contiguous push_valid");
      assert ((AW+1)'(pop_cnt) <= count) else $warning("pop_cnt exceeds count, clamped");
    end
endmodule

// File: rtl/queue_mp.sv
// queue_mp: multi-port flushable fetch queue with lane demux on write and rotate on read
module queue_mp import rv32i_types::*; #(
  parameter int DATA_W = $bits(fetch_queue_t),
  parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int PUSH_W = FQ_PUSH_W,
  parameter int POP_W = FQ_POP_W,
  parameter int AFULL_THRESH = FQ_AFULL
) (
  input logic clk,
  input logic rst,
  queue_mp_if.slave q
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic push_en;
  logic [DATA_W-1:0] mem [DEPTH];
  queue_ptr_ctrl #(
    .AW(ADDR_WIDTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .AFULL(AFULL_THRESH)
  ) u_ptr (
    .clk(clk),
    .rst(rst),
    .flush(q.flush),
    .push_valid(q.push_valid),
    .pop_cnt(q.pop_cnt),
    .rd_ptr(rd_ptr),
    .wr_ptr(wr_ptr),
    .count(q.count),
    .push_en(push_en),
    .push_ready(q.push_ready),
    .almost_full(q.almost_full)
  );
  // lane i lands at wr_ptr+i; the pointer wraps so a group may straddle the end of the array
  always_ff @(posedge clk)
    for (int i = 0; i < PUSH_W; i++)
      if (push_en && q.push_valid[i]) mem[wr_ptr + ADDR_WIDTH'(i)] <= q.push_data[i*DATA_W +: DATA_W];
  for (genvar g = 0; g < POP_W; g++) begin : g_rd
    assign q.out_data[g*DATA_W +: DATA_W] = mem[rd_ptr + ADDR_WIDTH'(g)];
    assign q.out_valid[g] = q.count > (ADDR_WIDTH+1)'(g);
  end
endmodule
